dpram_be_clr: RTL and testbench

//   Single-clock true dual-port RAM with per-byte write enables, selectable

---
 rtl/dpram_be_clr.sv | 154 +++++++++++++++
 tb/tb_dpram_be_clr.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_be_clr.sv
// True dual-port RAM with byte enables, selectable read-during-write behaviour,
// optional output register and a zero-fill engine that runs after reset or on request.
`timescale 1ns/1ps
module dpram_be_clr #(
    parameter int address_width  = 10,
    parameter int data_width     = 16,
    parameter int byte_width     = 8,
    parameter int rdw_mode       = 0,
    parameter int output_reg     = 0,
    parameter int clear_on_reset = 1
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               clear,
    output logic                               ready,
    input  logic                               enable_a,
    input  logic                               wren_a,
    input  logic [data_width/byte_width-1:0]   byteen_a,
    input  logic [address_width-1:0]           address_a,
    input  logic [data_width-1:0]              data_a,
    output logic [data_width-1:0]              q_a,
    input  logic                               enable_b,
    input  logic                               wren_b,
    input  logic [data_width/byte_width-1:0]   byteen_b,
    input  logic [address_width-1:0]           address_b,
    input  logic [data_width-1:0]              data_b,
    output logic [data_width-1:0]              q_b
);

    localparam int lanes = data_width / byte_width;
    localparam int depth = 1 << address_width;
    localparam logic [address_width-1:0] clr_last = '1;

    if (data_width % byte_width != 0) begin : g_bad_width
        $error("dpram_be_clr: data_width must be a multiple of byte_width");
    end

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t                   state, state_next;
    logic [address_width-1:0] clr_addr, clr_addr_next;

    logic [data_width-1:0] mem [depth];

    logic             acc_a, acc_b;
    logic [lanes-1:0] we_a, we_b, we_b_eff;
    logic [data_width-1:0] old_a, old_b, rd_a, rd_b;
    logic [data_width-1:0] q1_a, q1_b;

    function automatic logic [data_width-1:0] merge_lanes(
        input logic [data_width-1:0] old_word,
        input logic [data_width-1:0] new_word,
        input logic [lanes-1:0]      lane_en
    );
        logic [data_width-1:0] result;
        result = old_word;
        for (int l = 0; l < lanes; l++) begin
            if (lane_en[l]) result[l*byte_width +: byte_width] = new_word[l*byte_width +: byte_width];
        end
        return result;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= (clear_on_reset != 0) ? ST_CLEAR : ST_IDLE;
            clr_addr <= '0;
        end else begin
            state    <= state_next;
            clr_addr <= clr_addr_next;
        end
    end

    // NOTE: every output of this block is defaulted first so no latch can be inferred.
    always_comb begin
        state_next    = state;
        clr_addr_next = clr_addr;
        case (state)
            ST_IDLE: begin
                if (clear) begin
                    state_next    = ST_CLEAR;
                    clr_addr_next = '0;
                end
            end
            ST_CLEAR: begin
                if (clear) begin
                    clr_addr_next = '0;
                end else if (clr_addr == clr_last) begin
                    state_next    = ST_IDLE;
                    clr_addr_next = '0;
                end else begin
                    clr_addr_next = clr_addr + address_width'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign ready = (state == ST_IDLE);

    assign acc_a = ready & enable_a;
    assign acc_b = ready & enable_b;
    assign we_a  = (acc_a & wren_a) ? byteen_a : '0;
    assign we_b  = (acc_b & wren_b) ? byteen_b : '0;
    // Port A owns any lane both ports write at the same address.
    assign we_b_eff = (address_a == address_b) ? (we_b & ~we_a) : we_b;

    // NOTE: the array is deliberately not reset; only the clear sweep zeroes it.
    always_ff @(posedge clock) begin
        if (state == ST_CLEAR) begin
            mem[clr_addr] <= '0;
        end else begin
            for (int l = 0; l < lanes; l++) begin
                if (we_a[l])     mem[address_a][l*byte_width +: byte_width] <= data_a[l*byte_width +: byte_width];
                if (we_b_eff[l]) mem[address_b][l*byte_width +: byte_width] <= data_b[l*byte_width +: byte_width];
            end
        end
    end

    assign old_a = mem[address_a];
    assign old_b = mem[address_b];
    // Each port only ever sees its own write merged in; the other port's write lands after the read.
    assign rd_a  = (rdw_mode == 0) ? merge_lanes(old_a, data_a, we_a) : old_a;
    assign rd_b  = (rdw_mode == 0) ? merge_lanes(old_b, data_b, we_b) : old_b;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q1_a <= '0;
            q1_b <= '0;
        end else begin
            if (acc_a) q1_a <= rd_a;
            if (acc_b) q1_b <= rd_b;
        end
    end

    if (output_reg != 0) begin : g_out_reg
        logic [data_width-1:0] q2_a, q2_b;
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                q2_a <= '0;
                q2_b <= '0;
            end else begin
                q2_a <= q1_a;
                q2_b <= q1_b;
            end
        end
        assign q_a = q2_a;
        assign q_b = q2_b;
    end else begin : g_no_out_reg
        assign q_a = q1_a;
        assign q_b = q1_b;
    end

endmodule

// File: tb/tb_dpram_be_clr.sv
// Bench for dpram_be_clr: two instances (new-data/no output reg, old-data/output reg)
// share stimulus and are compared against a word-array reference model.
`timescale 1ns/1ps
module tb_dpram_be_clr;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic        enable_a = 1'b0, wren_a = 1'b0, enable_b = 1'b0, wren_b = 1'b0;
    logic [1:0]  byteen_a = '0, byteen_b = '0;
    logic [3:0]  address_a = '0, address_b = '0;
    logic [15:0] data_a = '0, data_b = '0;
    logic        ready0, ready1;
    logic [15:0] q_a0, q_b0, q_a1, q_b1;

    int checks = 0;
    int fails  = 0;

    // reference model
    logic [15:0] mem_m [16];
    bit          busy_m;
    int          ptr_m;
    logic [15:0] m0_qa, m0_qb, m1_sa, m1_sb, m1_qa, m1_qb;

    always #5 clock = ~clock;

    dpram_be_clr #(.address_width(4), .data_width(16), .byte_width(8), .rdw_mode(0),
                   .output_reg(0), .clear_on_reset(1)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .clear(clear), .ready(ready0),
        .enable_a(enable_a), .wren_a(wren_a), .byteen_a(byteen_a), .address_a(address_a),
        .data_a(data_a), .q_a(q_a0),
        .enable_b(enable_b), .wren_b(wren_b), .byteen_b(byteen_b), .address_b(address_b),
        .data_b(data_b), .q_b(q_b0));

    dpram_be_clr #(.address_width(4), .data_width(16), .byte_width(8), .rdw_mode(1),
                   .output_reg(1), .clear_on_reset(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .clear(clear), .ready(ready1),
        .enable_a(enable_a), .wren_a(wren_a), .byteen_a(byteen_a), .address_a(address_a),
        .data_a(data_a), .q_a(q_a1),
        .enable_b(enable_b), .wren_b(wren_b), .byteen_b(byteen_b), .address_b(address_b),
        .data_b(data_b), .q_b(q_b1));

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n, input logic [1:0] be);
        logic [15:0] r;
        r = o;
        for (int l = 0; l < 2; l++) if (be[l]) r[l*8 +: 8] = n[l*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        busy_m = 1'b1; ptr_m = 0;
        m0_qa = '0; m0_qb = '0; m1_sa = '0; m1_sb = '0; m1_qa = '0; m1_qb = '0;
    endtask

    // One clock: model follows the edge, returns at the following falling edge.
    task automatic tick();
        logic [15:0] old_a, old_b;
        bit acc_a, acc_b, wa, wb;
        @(posedge clock);
        old_a = mem_m[address_a];
        old_b = mem_m[address_b];
        acc_a = !busy_m && enable_a;
        acc_b = !busy_m && enable_b;
        m1_qa = m1_sa;
        m1_qb = m1_sb;
        if (acc_a) begin
            m0_qa = wren_a ? merge(old_a, data_a, byteen_a) : old_a;
            m1_sa = old_a;
        end
        if (acc_b) begin
            m0_qb = wren_b ? merge(old_b, data_b, byteen_b) : old_b;
            m1_sb = old_b;
        end
        if (busy_m) begin
            mem_m[ptr_m] = '0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                wa = acc_a && wren_a && byteen_a[l];
                wb = acc_b && wren_b && byteen_b[l] && !(wa && address_a == address_b);
                if (wa) mem_m[address_a][l*8 +: 8] = data_a[l*8 +: 8];
                if (wb) mem_m[address_b][l*8 +: 8] = data_b[l*8 +: 8];
            end
        end
        if (busy_m) begin
            if (clear) ptr_m = 0;
            else if (ptr_m == 15) begin busy_m = 1'b0; ptr_m = 0; end
            else ptr_m++;
        end else if (clear) begin
            busy_m = 1'b1; ptr_m = 0;
        end
        @(negedge clock);
    endtask

    task automatic set_a(input bit en, input bit wr, input logic [1:0] be, input logic [3:0] ad, input logic [15:0] d);
        enable_a = en; wren_a = wr; byteen_a = be; address_a = ad; data_a = d;
    endtask

    task automatic set_b(input bit en, input bit wr, input logic [1:0] be, input logic [3:0] ad, input logic [15:0] d);
        enable_b = en; wren_b = wr; byteen_b = be; address_b = ad; data_b = d;
    endtask

    task automatic idle();
        set_a(0, 0, 2'b00, 4'd0, 16'h0);
        set_b(0, 0, 2'b00, 4'd0, 16'h0);
    endtask

    task automatic wait_sweep(input string tag);
        int n = 0;
        while (ready0 !== 1'b1 && n < 40) begin tick(); n++; end
        checks++;
        if (n !== 16) begin fails++; $display("FAIL %s_len: busy for %0d clocks, expected 16", tag, n); end
        checks++;
        if (ready1 !== 1'b1) begin fails++; $display("FAIL %s_ready1: got %b expected 1", tag, ready1); end
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            set_a(1, 0, 2'b00, 4'(i), 16'h0);
            set_b(1, 0, 2'b00, 4'(15 - i), 16'h0);
            tick();
            checks++;
            if (q_a0 !== 16'h0000 || q_b0 !== 16'h0000) begin
                fails++; $display("FAIL %s_zero[%0d]: q_a=%h q_b=%h expected 0000", tag, i, q_a0, q_b0);
            end
        end
        idle();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) mem_m[i] = '0;
        model_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (ready0 !== 1'b0 || ready1 !== 1'b0) begin fails++; $display("FAIL rst_ready: %b %b expected 0 0", ready0, ready1); end
        checks++;
        if ({q_a0, q_b0, q_a1, q_b1} !== 64'h0) begin fails++; $display("FAIL rst_q: %h %h %h %h expected 0", q_a0, q_b0, q_a1, q_b1); end
        reset_n = 1'b1;
        wait_sweep("rst_sweep");
        read_all_zero("rst");
    endtask

    task automatic test_byte_merge();
        set_a(1, 1, 2'b11, 4'd3, 16'hBEEF); tick();
        set_a(1, 1, 2'b01, 4'd3, 16'h0012); tick();
        checks++;
        if (q_a0 !== 16'hBE12) begin fails++; $display("FAIL merge_rdw: q_a=%h expected be12", q_a0); end
        set_a(1, 0, 2'b00, 4'd3, 16'h0); tick();
        checks++;
        if (q_a0 !== 16'hBE12) begin fails++; $display("FAIL merge_read: q_a=%h expected be12", q_a0); end
        idle(); tick();
        checks++;
        if (q_a1 !== 16'hBE12) begin fails++; $display("FAIL merge_read_reg: q_a1=%h expected be12", q_a1); end
    endtask

    task automatic test_rdw();
        set_a(1, 1, 2'b11, 4'd5, 16'hAAAA); tick();
        set_a(1, 1, 2'b11, 4'd5, 16'h1234);
        set_b(1, 0, 2'b00, 4'd5, 16'h0);
        tick();
        checks++;
        if (q_a0 !== 16'h1234) begin fails++; $display("FAIL rdw_new_a: q_a=%h expected 1234", q_a0); end
        checks++;
        if (q_b0 !== 16'hAAAA) begin fails++; $display("FAIL rdw_cross_b0: q_b=%h expected aaaa", q_b0); end
        idle(); tick();
        checks++;
        if (q_a1 !== 16'hAAAA) begin fails++; $display("FAIL rdw_old_a: q_a1=%h expected aaaa", q_a1); end
        checks++;
        if (q_b1 !== 16'hAAAA) begin fails++; $display("FAIL rdw_cross_b1: q_b1=%h expected aaaa", q_b1); end
    endtask

    task automatic test_dual_write();
        set_a(1, 1, 2'b01, 4'd7, 16'h1111);
        set_b(1, 1, 2'b11, 4'd7, 16'h2222);
        tick();
        idle(); set_a(1, 0, 2'b00, 4'd7, 16'h0); tick();
        checks++;
        if (q_a0 !== 16'h2211) begin fails++; $display("FAIL dual_mixed: q_a=%h expected 2211", q_a0); end
        set_a(1, 1, 2'b11, 4'd7, 16'h1111);
        set_b(1, 1, 2'b11, 4'd7, 16'h2222);
        tick();
        idle(); set_b(1, 0, 2'b00, 4'd7, 16'h0); tick();
        checks++;
        if (q_b0 !== 16'h1111) begin fails++; $display("FAIL dual_full: q_b=%h expected 1111", q_b0); end
        idle();
    endtask

    task automatic test_latency();
        set_a(1, 1, 2'b11, 4'd11, 16'hC3C3); tick();
        idle(); tick();
        checks++;
        if (q_a1 !== 16'h0000) begin fails++; $display("FAIL lat_pre: q_a1=%h expected 0000", q_a1); end
        set_a(1, 0, 2'b00, 4'd11, 16'h0); tick();
        checks++;
        if (q_a1 !== 16'h0000) begin fails++; $display("FAIL lat_1clk: q_a1=%h expected 0000", q_a1); end
        checks++;
        if (q_a0 !== 16'hC3C3) begin fails++; $display("FAIL lat_noreg: q_a0=%h expected c3c3", q_a0); end
        idle(); tick();
        checks++;
        if (q_a1 !== 16'hC3C3) begin fails++; $display("FAIL lat_2clk: q_a1=%h expected c3c3", q_a1); end
    endtask

    task automatic test_clear_sweep();
        int guard = 0;
        set_a(1, 1, 2'b11, 4'd2, 16'h5A5A); tick();
        set_a(1, 0, 2'b00, 4'd2, 16'h0); set_b(1, 0, 2'b00, 4'd2, 16'h0); tick();
        idle(); clear = 1'b1; tick(); clear = 1'b0;
        checks++;
        if (ready0 !== 1'b0) begin fails++; $display("FAIL clr_start: ready=%b expected 0", ready0); end
        while (ptr_m != 7 && guard < 40) begin
            set_a(1, 1, 2'b11, 4'($urandom_range(0, 15)), 16'($urandom));
            set_b(1, 1, 2'b11, 4'($urandom_range(0, 15)), 16'($urandom));
            tick();
            guard++;
            checks++;
            if (ready0 !== 1'b0 || q_a0 !== 16'h5A5A || q_b0 !== 16'h5A5A) begin
                fails++; $display("FAIL clr_hold: ready=%b q_a=%h q_b=%h expected 0 5a5a 5a5a", ready0, q_a0, q_b0);
            end
        end
        checks++;
        if (ptr_m != 7) begin fails++; $display("FAIL clr_reach7: pointer %0d expected 7", ptr_m); end
        idle();
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (ready0 !== 1'b0 || ready1 !== 1'b0) begin fails++; $display("FAIL abort_ready: %b %b expected 0 0", ready0, ready1); end
        checks++;
        if ({q_a0, q_b0, q_a1, q_b1} !== 64'h0) begin fails++; $display("FAIL abort_q: %h %h %h %h expected 0", q_a0, q_b0, q_a1, q_b1); end
        @(negedge clock);
        reset_n = 1'b1;
        wait_sweep("abort_sweep");
        read_all_zero("abort");
    endtask

    task automatic test_random();
        logic [3:0] ad;
        for (int c = 0; c < 300; c++) begin
            ad = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            set_a(1'($urandom), 1'($urandom), 2'($urandom), ad, 16'($urandom));
            ad = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            set_b(1'($urandom), 1'($urandom), 2'($urandom), ad, 16'($urandom));
            clear = ($urandom_range(0, 63) == 0);
            tick();
            checks++;
            if (ready0 !== (busy_m ? 1'b0 : 1'b1)) begin fails++; $display("FAIL rnd_ready c%0d: got %b busy=%b", c, ready0, busy_m); end
            checks++;
            if (q_a0 !== m0_qa) begin fails++; $display("FAIL rnd_qa0 c%0d: got %h expected %h", c, q_a0, m0_qa); end
            checks++;
            if (q_b0 !== m0_qb) begin fails++; $display("FAIL rnd_qb0 c%0d: got %h expected %h", c, q_b0, m0_qb); end
            checks++;
            if (q_a1 !== m1_qa) begin fails++; $display("FAIL rnd_qa1 c%0d: got %h expected %h", c, q_a1, m1_qa); end
            checks++;
            if (q_b1 !== m1_qb) begin fails++; $display("FAIL rnd_qb1 c%0d: got %h expected %h", c, q_b1, m1_qb); end
        end
        clear = 1'b0;
        idle();
    endtask

    initial begin
        test_reset();
        test_byte_merge();
        test_rdw();
        test_dual_write();
        test_latency();
        test_clear_sweep();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
